// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, combinational imem address, IF/ID register, halt drain FSM.
// Latency: instruction at PC=A appears on IF/ID one edge later; redirect costs one bubble.
// Backpressure: stall holds PC, IF/ID, fetch count and drain counter; redirect overrides stall.
module if_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc1,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc1_q, pc1_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;

  logic [15:0] pc_inc;
  logic        is_halt;

  assign pc_inc  = pc_q + 16'd1;
  assign is_halt = (imem_instr[15:10] == 6'b111111);

  // Next-state logic: redirect beats stall; once halted only reset leaves.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc1_d         = pc1_q;
    valid_d       = valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    drain_cnt_d   = drain_cnt_q;

    case (state_q)
      ST_HALTED: begin
        instr_d = 16'h0000;
        pc1_d   = 16'h0000;
        valid_d = 1'b0;
      end
      default: begin
        if (redirect) begin
          // Also squashes a halt sitting in a branch shadow.
          pc_d        = redirect_pc;
          instr_d     = 16'h0000;
          pc1_d       = 16'h0000;
          valid_d     = 1'b0;
          state_d     = ST_RUN;
          drain_cnt_d = 4'd0;
        end else if (!stall) begin
          if (state_q == ST_DRAIN) begin
            instr_d     = 16'h0000;
            pc1_d       = 16'h0000;
            valid_d     = 1'b0;
            drain_cnt_d = drain_cnt_q - 4'd1;
            if (drain_cnt_q <= 4'd1) begin
              state_d     = ST_HALTED;
              halted_d    = 1'b1;
              drain_cnt_d = 4'd0;
            end
          end else begin
            instr_d = imem_instr;
            pc1_d   = pc_inc;
            valid_d = 1'b1;
            if (fetch_count_q != 16'hFFFF) begin
              fetch_count_d = fetch_count_q + 16'd1;
            end
            if (is_halt) begin
              // PC parks on the halt address while the pipe drains.
              state_d     = ST_DRAIN;
              drain_cnt_d = DRAIN_INIT;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      pc1_q         <= 16'h0000;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'h0000;
      drain_cnt_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc1_q         <= pc1_d;
      valid_q       <= valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule
